wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning fixed number of write-back requesters (0=ALU, 1=LSU, 2=MULDIV); other values unsupported.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req  input  3  per-requester write-back request.
REQ-005 The block SHALL have port req_addr  input  15  destination register, requester i at bits [5i+4:5i].
REQ-006 The block SHALL have port req_data  input  96  write data, requester i at bits [32i+31:32i].
REQ-007 The block SHALL have port gnt  output  3  one-hot grant, combinational, same cycle as req.
REQ-008 The block SHALL have port we3  output  1  registered register-file write enable.
REQ-009 The block SHALL have port addr3  output  5  registered register-file write address.
REQ-010 The block SHALL have port write3  output  32  registered register-file write data.
REQ-011 The block SHALL have port issue_valid  input  1  decode stage presents an instruction.
REQ-012 The block SHALL have port issue_we  input  1  presented instruction writes issue_rd.
REQ-013 The block SHALL have ports issue_rd, issue_rs1, issue_rs2  input  5 each  destination and source registers.
REQ-014 The block SHALL have port hazard  output  1  combinational stall request to decode.
REQ-015 The block SHALL have port busy  output  32  scoreboard bit vector; bit 0 constant 0.

Function
REQ-016 Requester SHALL hold req, req_addr, req_data stable until the cycle gnt[i] is high; gnt[i] high SHALL imply req[i] high.
REQ-017 At most one gnt bit SHALL be high per cycle; gnt SHALL be 0 when req==0.
REQ-018 Arbitration SHALL be round-robin: search order starts at pointer ptr (0..2), ascending, wrapping 2->0.
REQ-019 On a grant to i, ptr SHALL become (i+1) mod 3 at the next edge; with no grant, ptr SHALL be unchanged.
REQ-020 At the edge ending a grant cycle, the block SHALL register we3=1 (0 if granted addr==0), addr3=granted addr, write3=granted data; latency exactly 1 cycle.
REQ-021 In a cycle following no grant, we3 SHALL be 0, addr3 and write3 SHALL hold previous values.
REQ-022 A request to register 0 SHALL be granted and retired normally but SHALL NOT assert we3 and SHALL NOT affect busy.
REQ-023 hazard SHALL equal issue_valid AND (busy[issue_rs1] OR busy[issue_rs2] OR (issue_we AND busy[issue_rd])), using registered busy only.
REQ-024 busy[issue_rd] SHALL set at the edge when issue_valid=1, issue_we=1, hazard=0, issue_rd!=0.
REQ-025 busy[a] SHALL clear at the edge ending a grant cycle with granted addr a!=0.
REQ-026 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-027 busy clear and we3 assertion SHALL occur at the same edge, so a dependent read in the next cycle is served by register-file write bypass.
REQ-028 Requests targeting a non-busy register SHALL still be granted and written (no scoreboard check on write-back).

Reset
REQ-029 While reset_n=0: ptr=0, busy=0, we3=0, addr3=0, write3=0, gnt=0 regardless of req.
REQ-030 Reset assertion mid-grant SHALL discard the captured write; no we3 pulse SHALL follow deassertion.
REQ-031 After reset deassertion, the first grant SHALL follow REQ-018 with ptr=0.

Verification
REQ-032 req=3'b111 held, addrs 1/2/3 -> gnt sequence 001,010,100,001; we3 pulses each next cycle with matching addr3/write3.
REQ-033 req=3'b100 only, addr 7, data 32'hDEADBEEF -> gnt=100 same cycle; next cycle we3=1, addr3=7, write3=32'hDEADBEEF; ptr=0.
REQ-034 Issue rd=5 (busy[5]=1), then issue rs1=5 -> hazard=1 until LSU write to 5 granted; next cycle busy[5]=0, hazard=0.
REQ-035 Same cycle: grant clears r9 and issue sets r9 -> busy[9]=1 afterwards.
REQ-036 req=3'b001 addr 0 -> gnt=001, next cycle we3=0, busy unchanged; issue rd=0 never sets busy, hazard=0.
REQ-037 reset_n pulsed low during grant cycle -> busy=0, we3=0 after release, next grant from ptr=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter with register scoreboard
module wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [5*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 we3,
  output logic [4:0]           addr3,
  output logic [31:0]          write3,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           issue_rs1,
  input  logic [4:0]           issue_rs2,
  output logic                 hazard,
  output logic [31:0]          busy
);

  logic [1:0]      ptr;
  logic [1:0]      gnt_idx;
  logic [1:0]      cand;
  logic [2:0]      sum;
  logic [NREQ-1:0] gnt_rr;
  logic            any_gnt;
  logic [4:0]      g_addr;
  logic [31:0]     g_data;
  logic            issue_set;
  logic [31:0]     busy_nxt;

  // Search starts at ptr and wraps; the first requester found wins.
  always_comb begin
    gnt_rr  = '0;
    gnt_idx = ptr;
    cand    = ptr;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum  = {1'b0, ptr} + 3'(k);
      cand = (sum >= 3'(NREQ)) ? 2'(sum - 3'(NREQ)) : sum[1:0];
      if (gnt_rr == '0 && req[cand]) begin
        gnt_rr[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  assign gnt     = reset_n ? gnt_rr : '0;
  assign any_gnt = |gnt_rr;
  assign g_addr  = req_addr[5*gnt_idx +: 5];
  assign g_data  = req_data[32*gnt_idx +: 32];

  assign hazard = issue_valid &
                  (busy[issue_rs1] | busy[issue_rs2] | (issue_we & busy[issue_rd]));
  assign issue_set = issue_valid & issue_we & ~hazard & (issue_rd != 5'd0);

  // Set is applied after clear so a same-cycle set/clear leaves the bit set.
  always_comb begin
    busy_nxt = busy;
    if (any_gnt)
      busy_nxt[g_addr] = 1'b0;
    if (issue_set)
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr    <= 2'd0;
      busy   <= '0;
      we3    <= 1'b0;
      addr3  <= '0;
      write3 <= '0;
    end else begin
      busy <= busy_nxt;
      we3  <= any_gnt && (g_addr != 5'd0);
      if (any_gnt) begin
        addr3  <= g_addr;
        write3 <= g_data;
        ptr    <= (gnt_idx == 2'(NREQ-1)) ? 2'd0 : gnt_idx + 2'd1;
      end
    end
  end

endmodule
